// File: rtl/plant_cell_animator_if.sv
// Command bus from game logic into the lawn animator: valid/ready handshake plus target cell.
interface plant_cell_animator_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [2:0] cmd_row;
  logic [3:0] cmd_col;
  logic [2:0] cmd_plant;

  modport master (
    output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_plant,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_plant,
    output cmd_ready
  );
endinterface

// File: rtl/plant_cell_animator.sv
// Per-cell plant animation state for the 9x5 lawn with vblank-gated commands and a
// registered per-pixel lookup feeding the sprite renderer.
module plant_cell_animator #(
  parameter int unsigned LAWN_X0   = 64,
  parameter int unsigned LAWN_Y0   = 96,
  parameter int unsigned FRAME_DIV = 6
) (
  input  logic                        vga_clk,
  input  logic                        reset_n,
  input  logic                        vsync,
  input  logic [9:0]                  DrawX,
  input  logic [9:0]                  DrawY,
  plant_cell_animator_if.slave        cmd,
  output logic                        cell_valid,
  output logic [2:0]                  plant,
  output logic [2:0]                  animation,
  output logic [4:0]                  local_x,
  output logic [4:0]                  local_y
);
  localparam int unsigned NumCells = 45;

  localparam logic [1:0] StEmpty  = 2'd0;
  localparam logic [1:0] StIdle   = 2'd1;
  localparam logic [1:0] StAttack = 2'd2;

  localparam logic [1:0] OpPlace  = 2'b01;
  localparam logic [1:0] OpRemove = 2'b10;
  localparam logic [1:0] OpAttack = 2'b11;

  localparam logic [9:0] XLo     = 10'(LAWN_X0);
  localparam logic [9:0] XHi     = 10'(LAWN_X0 + 576);
  localparam logic [9:0] YLo     = 10'(LAWN_Y0);
  localparam logic [9:0] YHi     = 10'(LAWN_Y0 + 320);
  localparam logic [9:0] VblankY = 10'd480;
  localparam logic [3:0] DivLast = 4'(FRAME_DIV - 1);

  // Tick generation
  logic       vsync_q;
  logic [3:0] div_q, div_d;
  logic       vs_fall, tick;

  assign vs_fall = vsync_q & ~vsync;
  assign tick    = vs_fall & (div_q == DivLast);

  always_comb begin
    div_d = div_q;
    if (vs_fall) div_d = tick ? 4'd0 : div_q + 4'd1;
  end

  // Single pending command slot
  logic       pend_q;
  logic [1:0] pend_op_q;
  logic [2:0] pend_row_q, pend_plant_q;
  logic [3:0] pend_col_q;
  logic       accept, apply, pend_hit;
  logic [5:0] pend_idx;

  assign cmd.cmd_ready = ~pend_q;
  assign accept        = cmd.cmd_valid & ~pend_q;
  assign apply         = pend_q & (DrawY >= VblankY);
  assign pend_hit      = apply & (pend_row_q <= 3'd4) & (pend_col_q <= 4'd8);
  assign pend_idx      = 6'(pend_row_q) * 6'd9 + 6'(pend_col_q);

  // Cell array
  logic [1:0] state_q [NumCells];
  logic [1:0] state_d [NumCells];
  logic [2:0] plant_q [NumCells];
  logic [2:0] plant_d [NumCells];
  logic [2:0] frame_q [NumCells];
  logic [2:0] frame_d [NumCells];

  always_comb begin
    for (int i = 0; i < NumCells; i++) begin
      state_d[i] = state_q[i];
      plant_d[i] = plant_q[i];
      frame_d[i] = frame_q[i];
      if (tick) begin
        case (state_q[i])
          StIdle:   frame_d[i] = (frame_q[i] == 3'd5) ? 3'd0 : frame_q[i] + 3'd1;
          StAttack: begin
            if (frame_q[i] == 3'd7) begin
              state_d[i] = StIdle;
              frame_d[i] = 3'd0;
            end else begin
              frame_d[i] = 3'd7;
            end
          end
          default: ;
        endcase
      end
      // Command overrides the tick for its target cell
      if (pend_hit && (pend_idx == 6'(i))) begin
        case (pend_op_q)
          OpPlace: begin
            state_d[i] = StIdle;
            plant_d[i] = pend_plant_q;
            frame_d[i] = 3'd0;
          end
          OpRemove: begin
            state_d[i] = StEmpty;
            plant_d[i] = 3'd0;
            frame_d[i] = 3'd0;
          end
          OpAttack: begin
            if (state_q[i] != StEmpty) begin
              state_d[i] = StAttack;
              frame_d[i] = 3'd6;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Pixel lookup
  logic [9:0] rel_x, rel_y;
  logic       in_lawn, look_occ;
  logic [5:0] look_idx;
  logic       unused_bits;

  assign rel_x       = DrawX - XLo;
  assign rel_y       = DrawY - YLo;
  assign in_lawn     = (DrawX >= XLo) && (DrawX < XHi) && (DrawY >= YLo) && (DrawY < YHi);
  assign look_idx    = in_lawn ? 6'(rel_y[8:6]) * 6'd9 + 6'(rel_x[9:6]) : 6'd0;
  assign look_occ    = in_lawn && (state_q[look_idx] != StEmpty);
  assign unused_bits = ^{rel_x[0], rel_y[0], rel_y[9]};

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      vsync_q      <= 1'b1;
      div_q        <= 4'd0;
      pend_q       <= 1'b0;
      pend_op_q    <= 2'd0;
      pend_row_q   <= 3'd0;
      pend_col_q   <= 4'd0;
      pend_plant_q <= 3'd0;
      for (int i = 0; i < NumCells; i++) begin
        state_q[i] <= StEmpty;
        plant_q[i] <= 3'd0;
        frame_q[i] <= 3'd0;
      end
      cell_valid <= 1'b0;
      plant      <= 3'd0;
      animation  <= 3'd0;
      local_x    <= 5'd0;
      local_y    <= 5'd0;
    end else begin
      vsync_q <= vsync;
      div_q   <= div_d;
      if (apply) begin
        pend_q <= 1'b0;
      end else if (accept) begin
        pend_q       <= 1'b1;
        pend_op_q    <= cmd.cmd_op;
        pend_row_q   <= cmd.cmd_row;
        pend_col_q   <= cmd.cmd_col;
        pend_plant_q <= cmd.cmd_plant;
      end
      for (int i = 0; i < NumCells; i++) begin
        state_q[i] <= state_d[i];
        plant_q[i] <= plant_d[i];
        frame_q[i] <= frame_d[i];
      end
      cell_valid <= look_occ;
      plant      <= look_occ ? plant_q[look_idx] : 3'd0;
      animation  <= look_occ ? frame_q[look_idx] : 3'd0;
      local_x    <= look_occ ? rel_x[5:1] : 5'd0;
      local_y    <= look_occ ? rel_y[5:1] : 5'd0;
    end
  end
endmodule

// File: tb/tb_plant_cell_animator.sv
// Bench for plant_cell_animator: constant vector table, directed corner sequences and a
// randomized run against a cell-level reference model.
module tb_plant_cell_animator;
  localparam int FD = 6;

  logic       vga_clk = 1'b0;
  logic       reset_n;
  logic       vsync;
  logic [9:0] DrawX, DrawY;
  logic       cell_valid;
  logic [2:0] plant, animation;
  logic [4:0] local_x, local_y;

  plant_cell_animator_if cmd_if ();

  plant_cell_animator #(
    .LAWN_X0   (64),
    .LAWN_Y0   (96),
    .FRAME_DIV (FD)
  ) dut (
    .vga_clk    (vga_clk),
    .reset_n    (reset_n),
    .vsync      (vsync),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .cmd        (cmd_if),
    .cell_valid (cell_valid),
    .plant      (plant),
    .animation  (animation),
    .local_x    (local_x),
    .local_y    (local_y)
  );

  always #5 vga_clk = ~vga_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: 0 empty, 1 idle, 2 attack
  int m_kind [45];
  int m_pl   [45];
  int m_fr   [45];
  int m_div;
  bit m_vs;
  bit m_pend;
  int m_op, m_row, m_col, m_plant;
  int e_valid, e_plant, e_anim, e_lx, e_ly, e_ready;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 45; i++) begin
      m_kind[i] = 0; m_pl[i] = 0; m_fr[i] = 0;
    end
    m_div = 0; m_vs = 1'b1; m_pend = 1'b0;
    e_valid = 0; e_plant = 0; e_anim = 0; e_lx = 0; e_ly = 0; e_ready = 1;
  endtask

  task automatic model_step();
    int x, y, i;
    bit fall, tk, ap, acc;
    x = int'(DrawX);
    y = int'(DrawY);
    e_valid = 0; e_plant = 0; e_anim = 0; e_lx = 0; e_ly = 0;
    if (x >= 64 && x < 640 && y >= 96 && y < 416) begin
      i = ((y - 96) / 64) * 9 + (x - 64) / 64;
      if (m_kind[i] != 0) begin
        e_valid = 1; e_plant = m_pl[i]; e_anim = m_fr[i];
        e_lx = ((x - 64) % 64) / 2; e_ly = ((y - 96) % 64) / 2;
      end
    end
    fall = m_vs && !vsync;
    tk = 1'b0;
    if (fall) begin
      m_div = (m_div + 1) % FD;
      tk = (m_div == 0);
    end
    ap  = m_pend && (y >= 480);
    acc = cmd_if.cmd_valid && !m_pend;
    if (tk) begin
      for (int c = 0; c < 45; c++) begin
        if (m_kind[c] == 1) m_fr[c] = (m_fr[c] + 1) % 6;
        else if (m_kind[c] == 2) begin
          if (m_fr[c] == 7) begin m_kind[c] = 1; m_fr[c] = 0; end
          else m_fr[c] = 7;
        end
      end
    end
    if (ap && m_row < 5 && m_col < 9) begin
      i = m_row * 9 + m_col;
      case (m_op)
        1: begin m_kind[i] = 1; m_pl[i] = m_plant; m_fr[i] = 0; end
        2: begin m_kind[i] = 0; m_pl[i] = 0; m_fr[i] = 0; end
        3: if (m_kind[i] != 0) begin m_kind[i] = 2; m_fr[i] = 6; end
        default: ;
      endcase
    end
    if (ap) m_pend = 1'b0;
    else if (acc) begin
      m_pend = 1'b1;
      m_op = int'(cmd_if.cmd_op); m_row = int'(cmd_if.cmd_row);
      m_col = int'(cmd_if.cmd_col); m_plant = int'(cmd_if.cmd_plant);
    end
    m_vs = vsync;
    e_ready = m_pend ? 0 : 1;
  endtask

  // Inputs are driven at the falling edge; outputs are sampled at the next falling edge
  task automatic cycle();
    if (!reset_n) model_reset();
    else model_step();
    @(posedge vga_clk);
    @(negedge vga_clk);
  endtask

  task automatic check_all(input string name);
    chk({name, ".cell_valid"}, int'(cell_valid), e_valid);
    chk({name, ".plant"}, int'(plant), e_plant);
    chk({name, ".animation"}, int'(animation), e_anim);
    chk({name, ".local_x"}, int'(local_x), e_lx);
    chk({name, ".local_y"}, int'(local_y), e_ly);
    chk({name, ".cmd_ready"}, int'(cmd_if.cmd_ready), e_ready);
  endtask

  task automatic vs_pulse();
    vsync = 1'b0; cycle();
    vsync = 1'b1; cycle();
  endtask

  task automatic issue_cmd(input int op, input int row, input int col, input int pl);
    DrawY = 10'd480;
    cmd_if.cmd_op = 2'(op); cmd_if.cmd_row = 3'(row);
    cmd_if.cmd_col = 4'(col); cmd_if.cmd_plant = 3'(pl);
    cmd_if.cmd_valid = 1'b1; cycle();
    cmd_if.cmd_valid = 1'b0; cycle();
  endtask

  task automatic look(input int x, input int y);
    DrawX = 10'(x); DrawY = 10'(y); cycle();
  endtask

  typedef struct {
    int op, row, col, pl, px, py;
    int v, p, a, lx, ly;
  } vec_t;
  vec_t tbl [12];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int pre, guard;
    tbl[0]  = '{1, 2, 3, 4, 276, 234, 1, 4, 0, 10, 5};
    tbl[1]  = '{1, 0, 0, 1, 64, 96, 1, 1, 0, 0, 0};
    tbl[2]  = '{1, 4, 8, 7, 639, 415, 1, 7, 0, 31, 31};
    tbl[3]  = '{3, 2, 3, 0, 277, 235, 1, 4, 6, 10, 5};
    tbl[4]  = '{2, 0, 0, 0, 64, 96, 0, 0, 0, 0, 0};
    tbl[5]  = '{3, 0, 0, 0, 100, 100, 0, 0, 0, 0, 0};
    tbl[6]  = '{1, 5, 0, 3, 64, 96, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 9, 3, 64, 96, 0, 0, 0, 0, 0};
    tbl[8]  = '{0, 4, 8, 2, 639, 415, 1, 7, 0, 31, 31};
    tbl[9]  = '{1, 2, 3, 2, 300, 250, 1, 2, 0, 22, 13};
    tbl[10] = '{1, 1, 1, 5, 10, 250, 0, 0, 0, 0, 0};
    tbl[11] = '{0, 0, 0, 0, 140, 420, 0, 0, 0, 0, 0};

    reset_n = 1'b0; vsync = 1'b1; DrawX = 10'd276; DrawY = 10'd234;
    cmd_if.cmd_valid = 1'b0; cmd_if.cmd_op = 2'd0; cmd_if.cmd_row = 3'd0;
    cmd_if.cmd_col = 4'd0; cmd_if.cmd_plant = 3'd0;
    model_reset();
    @(negedge vga_clk);
    cycle(); cycle();
    chk("reset.cell_valid", int'(cell_valid), 0);
    chk("reset.plant", int'(plant), 0);
    chk("reset.animation", int'(animation), 0);
    chk("reset.local_x", int'(local_x), 0);
    chk("reset.local_y", int'(local_y), 0);
    chk("reset.cmd_ready", int'(cmd_if.cmd_ready), 1);
    reset_n = 1'b1;

    // Vector table, all commands issued in vblank with vsync idle
    for (int k = 0; k < 12; k++) begin
      issue_cmd(tbl[k].op, tbl[k].row, tbl[k].col, tbl[k].pl);
      look(tbl[k].px, tbl[k].py);
      chk($sformatf("vec%0d.cell_valid", k), int'(cell_valid), tbl[k].v);
      chk($sformatf("vec%0d.plant", k), int'(plant), tbl[k].p);
      chk($sformatf("vec%0d.animation", k), int'(animation), tbl[k].a);
      chk($sformatf("vec%0d.local_x", k), int'(local_x), tbl[k].lx);
      chk($sformatf("vec%0d.local_y", k), int'(local_y), tbl[k].ly);
    end

    // Idle cycling: 36 vsync falls on cell (2,3)
    DrawX = 10'd300; DrawY = 10'd250;
    for (int k = 1; k <= 36; k++) begin
      vs_pulse();
      if (k % 6 == 0) chk($sformatf("idle_fall%0d.animation", k), int'(animation), (k / 6) % 6);
    end

    // Attack from idle frame 3
    for (int k = 0; k < 18; k++) vs_pulse();
    chk("pre_attack.animation", int'(animation), 3);
    issue_cmd(3, 2, 3, 0);
    look(300, 250);
    chk("attack.animation", int'(animation), 6);
    for (int k = 0; k < 6; k++) vs_pulse();
    chk("attack_tick1.animation", int'(animation), 7);
    for (int k = 0; k < 6; k++) vs_pulse();
    chk("attack_tick2.animation", int'(animation), 0);
    chk("attack_tick2.cell_valid", int'(cell_valid), 1);

    // Command accepted during active scan waits for vblank
    DrawX = 10'd197; DrawY = 10'd100;
    cmd_if.cmd_op = 2'd1; cmd_if.cmd_row = 3'd0; cmd_if.cmd_col = 4'd2; cmd_if.cmd_plant = 3'd6;
    cmd_if.cmd_valid = 1'b1; cycle();
    cmd_if.cmd_valid = 1'b0;
    chk("active.ready_after_accept", int'(cmd_if.cmd_ready), 0);
    cycle(); cycle(); cycle();
    chk("active.cell_valid_held", int'(cell_valid), 0);
    chk("active.ready_held", int'(cmd_if.cmd_ready), 0);
    DrawY = 10'd480; cycle();
    chk("active.ready_after_apply", int'(cmd_if.cmd_ready), 1);
    look(197, 100);
    chk("active.cell_valid", int'(cell_valid), 1);
    chk("active.plant", int'(plant), 6);
    check_all("active");

    // Command and tick on the same edge
    DrawX = 10'd197; DrawY = 10'd100;
    cmd_if.cmd_op = 2'd3; cmd_if.cmd_row = 3'd0; cmd_if.cmd_col = 4'd2;
    cmd_if.cmd_valid = 1'b1; cycle();
    cmd_if.cmd_valid = 1'b0;
    guard = 0;
    while (m_div != FD - 1 && guard < 20) begin vs_pulse(); guard++; end
    chk("collide.setup_guard", guard < 20 ? 1 : 0, 1);
    pre = m_fr[44];
    vsync = 1'b0; DrawY = 10'd480; cycle();
    vsync = 1'b1;
    look(197, 100);
    chk("collide.cmd_cell.animation", int'(animation), 6);
    check_all("collide.cmd_cell");
    look(639, 415);
    chk("collide.other_cell.animation", int'(animation), (pre + 1) % 6);
    check_all("collide.other_cell");

    // Reset discards a pending command
    DrawX = 10'd138; DrawY = 10'd170;
    cmd_if.cmd_op = 2'd1; cmd_if.cmd_row = 3'd1; cmd_if.cmd_col = 4'd1; cmd_if.cmd_plant = 3'd3;
    cmd_if.cmd_valid = 1'b1; cycle();
    cmd_if.cmd_valid = 1'b0;
    chk("rst_pend.ready_before", int'(cmd_if.cmd_ready), 0);
    look(197, 100);
    reset_n = 1'b0;
    #2;
    chk("rst_pend.cell_valid", int'(cell_valid), 0);
    chk("rst_pend.plant", int'(plant), 0);
    chk("rst_pend.animation", int'(animation), 0);
    chk("rst_pend.local_x", int'(local_x), 0);
    chk("rst_pend.local_y", int'(local_y), 0);
    chk("rst_pend.cmd_ready", int'(cmd_if.cmd_ready), 1);
    model_reset();
    @(negedge vga_clk);
    cycle();
    reset_n = 1'b1;
    DrawY = 10'd480;
    cycle(); cycle(); cycle();
    look(138, 170);
    chk("rst_pend.never_applied", int'(cell_valid), 0);
    check_all("rst_pend");

    // Randomized traffic against the model
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 2) == 0) vsync = ~vsync;
      DrawX = 10'($urandom_range(0, 799));
      DrawY = 10'(($urandom_range(0, 3) == 0) ? $urandom_range(470, 524) : $urandom_range(0, 524));
      cmd_if.cmd_valid = ($urandom_range(0, 3) == 0);
      cmd_if.cmd_op    = 2'($urandom_range(0, 3));
      cmd_if.cmd_row   = 3'($urandom_range(0, 5));
      cmd_if.cmd_col   = 4'($urandom_range(0, 9));
      cmd_if.cmd_plant = 3'($urandom_range(0, 7));
      cycle();
      check_all($sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/plant_cell_animator.md
# plant_cell_animator

Per-cell animation state for the 9x5 lawn, upstream of the plant sprite renderer. The block holds a plant type, state and frame index for each lawn cell, and steps every frame on a vsync-derived tick. It accepts place, remove and attack commands from game logic and applies them only in vertical blank, so nothing tears mid-frame. For every pixel it resolves the cell under DrawX/DrawY and returns a registered lookup: `plant`, `animation` and the sprite-local 32x32 coordinates, scaled 2x onto 64x64 cells. These are the values the renderer turns into a ROM address.

## Interface
- LAWN_X0, 64: left edge of lawn in pixels; cell pitch fixed at 64, 9 columns (x 64..639)
- LAWN_Y0, 96: top edge of lawn; cell pitch fixed at 64, 5 rows (y 96..415)
- FRAME_DIV, 6: vsync frames per animation step (1..15)
- vga_clk  in  1  pixel clock; the only clock
- reset_n  in  1  asynchronous, active-low reset
- vsync  in  1  active-low vertical sync from the VGA controller
- DrawX, DrawY  in  10 each  current pixel coordinates
- cmd_valid  in  1  command request
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 NOP, 01 PLACE, 10 REMOVE, 11 ATTACK
- cmd_row  in  3  cell row 0..4
- cmd_col  in  4  cell column 0..8
- cmd_plant  in  3  plant type for PLACE
- cell_valid  out  1  pixel lies in an occupied cell
- plant  out  3  plant type of that cell
- animation  out  3  frame index of that cell
- local_x, local_y  out  5 each  sprite-local coordinates = ((DrawX-LAWN_X0) mod 64)>>1, ((DrawY-LAWN_Y0) mod 64)>>1

## Operation
- Per-cell state machine, 45 instances: EMPTY, IDLE, ATTACK. Each cell stores 3-bit plant and 3-bit frame.
- Tick generation:
  - vsync falling edge is detected against a registered copy of vsync.
  - A divider counts edges 0..FRAME_DIV-1; tick fires on the edge that wraps it to 0.
- On tick, all cells update in parallel:
  - IDLE: frame 0..5 cycling, 5 wraps to 0.
  - ATTACK: frame 6 goes to 7; 7 goes to IDLE frame 0.
  - EMPTY: unchanged.
- Command path:
  - An accepted command is latched in a single pending register; cmd_ready=0 while it is pending.
  - The pending command is applied on the first cycle with DrawY >= 480.
- Command effects:
  - PLACE: state IDLE, plant=cmd_plant, frame 0. This overwrites an occupied cell.
  - REMOVE: state EMPTY. plant and frame are don't-care but driven out as 0.
  - ATTACK: applies to an IDLE or ATTACK cell, which goes to ATTACK frame 6. ATTACK mid-attack restarts at 6. ATTACK on EMPTY is ignored.
  - NOP, or row>4, or col>8: accepted and discarded with no state change.
- When a tick and a command apply to the same cell in the same cycle, the command wins. Other cells still take the tick.
- Lookup:
  - col = (DrawX-LAWN_X0)>>6 and row = (DrawY-LAWN_Y0)>>6, each computed only when the pixel is inside the lawn.
  - Outside the lawn, or in an EMPTY cell, all lookup outputs are 0.

## Timing
- Reset, asynchronous:
  - All cells go EMPTY with plant=0 and frame=0.
  - Pending command is cleared and the divider is set to 0.
  - cell_valid, plant, animation, local_x and local_y are 0.
  - cmd_ready is 1; the registered vsync copy is 1.
- Lookup latency: 1 vga_clk. Outputs at edge n+1 reflect DrawX/DrawY and cell state sampled at edge n.
- Handshake timing:
  - cmd_ready falls the cycle after acceptance.
  - The command takes effect at the first vblank edge, then cmd_ready rises the following cycle.
  - If accepted during vblank, the command is applied on the next cycle, so minimum accept-to-effect is 1 cycle.
- Tick timing: state changes at the clock edge after the detected vsync fall. vsync falls inside vertical blank, so visible frames are never updated mid-scan.
- Reset mid-operation discards any pending command. No partial update occurs.

## Test plan
- Reset, then place at row 2, col 3, plant 4 during vblank. Scan pixel (DrawX=276, DrawY=234): next cycle cell_valid=1, plant=4, animation=0, local_x=10, local_y=5.
- FRAME_DIV=6, IDLE cell: count 36 vsync falls. animation steps every 6th fall through 0,1,2,3,4,5, back to 0.
- ATTACK on an IDLE cell at frame 3. animation goes to 6, then 7 after one tick, then IDLE frame 0 after the next. ATTACK on an EMPTY cell leaves it cell_valid=0.
- Assert cmd_valid during active scan (DrawY=100). cmd_ready goes 0 and the cell is unchanged until DrawY=480. The change appears at that edge and cmd_ready returns 1 a cycle later.
- Command and tick land on the same cycle for the same cell: the command result is observed. A different IDLE cell advances normally.
- Invalid targets and reset:
  - cmd_row=5, or cmd_col=9: accepted, no state change.
  - Pixel DrawX=10: all lookup outputs 0.
  - Assert reset_n=0 with a command pending: all outputs 0, cmd_ready=1, and the command is never applied.
